// File: rtl/measure_duty_mc.sv
// measure_duty_mc: NUM_CH duty-cycle counters sharing one gate window, latched results with lock handshake.
// Optional per-channel rising-edge counters are enabled with the macro MEASURE_DUTY_EDGE_CNT_EN.
module measure_duty_mc #(
  parameter int CNT_WIDTH   = 32,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           sig_in,
  input  logic                        gate,
  input  logic                        cnt_lock,
  output logic [NUM_CH*CNT_WIDTH-1:0] high_cnt,
  output logic [CNT_WIDTH-1:0]        total_cnt,
  output logic [NUM_CH:0]             ovf,
  output logic                        cnt_valid,
  output logic                        dropped
`ifdef MEASURE_DUTY_EDGE_CNT_EN
  ,
  output logic [NUM_CH*CNT_WIDTH-1:0] edge_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_e                      state_q, state_d;
  logic [NUM_CH-1:0]           sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]           sync_d [SYNC_STAGES];
  logic [NUM_CH-1:0]           sync_sig;
  logic [CNT_WIDTH-1:0]        total_w_q, total_w_d;
  logic [CNT_WIDTH-1:0]        high_w_q [NUM_CH];
  logic [CNT_WIDTH-1:0]        high_w_d [NUM_CH];
  logic [NUM_CH:0]             ovf_w_q, ovf_w_d;
  logic [NUM_CH*CNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_WIDTH-1:0]        total_cnt_q, total_cnt_d;
  logic [NUM_CH:0]             ovf_q, ovf_d;
  logic                        cnt_valid_q, cnt_valid_d;
  logic                        dropped_q, dropped_d;
  logic                        start_s;
`ifdef MEASURE_DUTY_EDGE_CNT_EN
  logic [NUM_CH-1:0]           prev_q, prev_d;
  logic [NUM_CH-1:0]           rise_s;
  logic [CNT_WIDTH-1:0]        edge_w_q [NUM_CH];
  logic [CNT_WIDTH-1:0]        edge_w_d [NUM_CH];
  logic [NUM_CH*CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
`endif

  assign sync_sig = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    total_w_d   = total_w_q;
    high_w_d    = high_w_q;
    ovf_w_d     = ovf_w_q;
    high_cnt_d  = high_cnt_q;
    total_cnt_d = total_cnt_q;
    ovf_d       = ovf_q;
    cnt_valid_d = cnt_valid_q;
    dropped_d   = dropped_q;
    start_s     = 1'b0;
    sync_d[0]   = sig_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
`ifdef MEASURE_DUTY_EDGE_CNT_EN
    prev_d     = sync_sig;
    rise_s     = sync_sig & ~prev_q;
    edge_w_d   = edge_w_q;
    edge_cnt_d = edge_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (gate) begin
          start_s = 1'b1;
        end else begin
          total_w_d = '0;
          for (int i = 0; i < NUM_CH; i++) begin
            high_w_d[i] = '0;
`ifdef MEASURE_DUTY_EDGE_CNT_EN
            edge_w_d[i] = '0;
`endif
          end
        end
      end
      RUN: begin
        if (gate) begin
          // A saturated counter that is asked to count again records an overflow.
          ovf_w_d[NUM_CH] = ovf_w_q[NUM_CH] | (total_w_q == CNT_MAX);
          total_w_d       = sat_inc(total_w_q);
          for (int i = 0; i < NUM_CH; i++) begin
            if (sync_sig[i]) begin
              ovf_w_d[i]  = ovf_w_d[i] | (high_w_q[i] == CNT_MAX);
              high_w_d[i] = sat_inc(high_w_q[i]);
            end
`ifdef MEASURE_DUTY_EDGE_CNT_EN
            if (rise_s[i]) begin
              ovf_w_d[i]  = ovf_w_d[i] | (edge_w_q[i] == CNT_MAX);
              edge_w_d[i] = sat_inc(edge_w_q[i]);
            end
`endif
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!cnt_lock) begin
          for (int i = 0; i < NUM_CH; i++) begin
            high_cnt_d[i*CNT_WIDTH +: CNT_WIDTH] = high_w_q[i];
`ifdef MEASURE_DUTY_EDGE_CNT_EN
            edge_cnt_d[i*CNT_WIDTH +: CNT_WIDTH] = edge_w_q[i];
`endif
          end
          total_cnt_d = total_w_q;
          ovf_d       = ovf_w_q;
          cnt_valid_d = 1'b1;
          dropped_d   = 1'b0;
        end else begin
          dropped_d = 1'b1;
        end
        if (gate) begin
          start_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Window start is applied last so a back-to-back start follows the latch.
    if (start_s) begin
      state_d   = RUN;
      total_w_d = CNT_ONE;
      ovf_w_d   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        high_w_d[i] = CNT_WIDTH'(sync_sig[i]);
`ifdef MEASURE_DUTY_EDGE_CNT_EN
        edge_w_d[i] = CNT_WIDTH'(rise_s[i]);
`endif
      end
      if (!cnt_lock) begin
        cnt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      total_w_q   <= '0;
      ovf_w_q     <= '0;
      high_cnt_q  <= '0;
      total_cnt_q <= '0;
      ovf_q       <= '0;
      cnt_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        high_w_q[i] <= '0;
`ifdef MEASURE_DUTY_EDGE_CNT_EN
        edge_w_q[i] <= '0;
`endif
      end
`ifdef MEASURE_DUTY_EDGE_CNT_EN
      prev_q     <= '0;
      edge_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      total_w_q   <= total_w_d;
      ovf_w_q     <= ovf_w_d;
      high_cnt_q  <= high_cnt_d;
      total_cnt_q <= total_cnt_d;
      ovf_q       <= ovf_d;
      cnt_valid_q <= cnt_valid_d;
      dropped_q   <= dropped_d;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        high_w_q[i] <= high_w_d[i];
`ifdef MEASURE_DUTY_EDGE_CNT_EN
        edge_w_q[i] <= edge_w_d[i];
`endif
      end
`ifdef MEASURE_DUTY_EDGE_CNT_EN
      prev_q     <= prev_d;
      edge_cnt_q <= edge_cnt_d;
`endif
    end
  end

  assign high_cnt  = high_cnt_q;
  assign total_cnt = total_cnt_q;
  assign ovf       = ovf_q;
  assign cnt_valid = cnt_valid_q;
  assign dropped   = dropped_q;
`ifdef MEASURE_DUTY_EDGE_CNT_EN
  assign edge_cnt  = edge_cnt_q;
`endif

endmodule

// File: tb/tb_measure_duty_mc.sv
// Bench for measure_duty_mc: a 32-bit and an 8-bit instance share stimulus and are
// compared every cycle against a window-level reference model plus hand-written checks.
module tb_measure_duty_mc;
  localparam int S  = 2;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst_n, gate, cnt_lock;
  logic [NC-1:0] sig_in;

  logic [NC*32-1:0] hc32;
  logic [31:0]      tc32;
  logic [NC:0]      ov32;
  logic             v32, dr32;
  logic [NC*8-1:0]  hc8;
  logic [7:0]       tc8;
  logic [NC:0]      ov8;
  logic             v8, dr8;
`ifdef MEASURE_DUTY_EDGE_CNT_EN
  logic [NC*32-1:0] ec32;
  logic [NC*8-1:0]  ec8;
`endif

  always #5 clk = ~clk;

  measure_duty_mc #(.CNT_WIDTH(32), .NUM_CH(NC), .SYNC_STAGES(S)) dut32 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .gate(gate), .cnt_lock(cnt_lock),
    .high_cnt(hc32), .total_cnt(tc32), .ovf(ov32), .cnt_valid(v32), .dropped(dr32)
`ifdef MEASURE_DUTY_EDGE_CNT_EN
    , .edge_cnt(ec32)
`endif
  );

  measure_duty_mc #(.CNT_WIDTH(8), .NUM_CH(NC), .SYNC_STAGES(S)) dut8 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .gate(gate), .cnt_lock(cnt_lock),
    .high_cnt(hc8), .total_cnt(tc8), .ovf(ov8), .cnt_valid(v8), .dropped(dr8)
`ifdef MEASURE_DUTY_EDGE_CNT_EN
    , .edge_cnt(ec8)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: unbounded window tallies, saturated only when latched.
  logic [NC-1:0] sig_hist [0:19999];
  int     k_edge   = 0;
  int     last_rst = -1000;
  bit     m_active, m_pending;
  longint m_cnt;
  longint m_high [NC];
  longint m_edge [NC];
  longint e_total [2];
  longint e_high [2][NC];
  longint e_edge [2][NC];
  logic [NC:0] e_ovf [2];
  logic   e_valid, e_dropped;

  function automatic logic [NC-1:0] syncv(input int k);
    if (k - S >= 0 && k - S > last_rst) return sig_hist[k-S];
    return '0;
  endfunction

  function automatic longint satv(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic do_latch();
    longint mx;
    for (int w = 0; w < 2; w++) begin
      mx = (w == 0) ? 64'hFFFF_FFFF : 64'd255;
      e_total[w]    = satv(m_cnt, mx);
      e_ovf[w][NC]  = (m_cnt > mx);
      for (int c = 0; c < NC; c++) begin
        e_high[w][c] = satv(m_high[c], mx);
        e_edge[w][c] = satv(m_edge[c], mx);
`ifdef MEASURE_DUTY_EDGE_CNT_EN
        e_ovf[w][c]  = (m_high[c] > mx) || (m_edge[c] > mx);
`else
        e_ovf[w][c]  = (m_high[c] > mx);
`endif
      end
    end
  endtask

  task automatic model_step(input int k);
    logic [NC-1:0] sv, rs;
    sv = syncv(k);
    rs = sv & ~syncv(k - 1);
    if (!rst_n) begin
      last_rst = k;
      m_active = 0; m_pending = 0; m_cnt = 0;
      for (int w = 0; w < 2; w++) begin
        e_total[w] = 0; e_ovf[w] = '0;
        for (int c = 0; c < NC; c++) begin
          e_high[w][c] = 0; e_edge[w][c] = 0;
        end
      end
      for (int c = 0; c < NC; c++) begin
        m_high[c] = 0; m_edge[c] = 0;
      end
      e_valid = 1'b0; e_dropped = 1'b0;
    end else begin
      if (m_pending) begin
        m_pending = 0;
        if (!cnt_lock) begin
          do_latch();
          e_valid = 1'b1; e_dropped = 1'b0;
        end else begin
          e_dropped = 1'b1;
        end
      end
      if (m_active) begin
        if (gate) begin
          m_cnt++;
          for (int c = 0; c < NC; c++) begin
            m_high[c] += longint'(sv[c]);
            m_edge[c] += longint'(rs[c]);
          end
        end else begin
          m_active = 0; m_pending = 1;
        end
      end else if (gate) begin
        m_active = 1; m_cnt = 1;
        for (int c = 0; c < NC; c++) begin
          m_high[c] = longint'(sv[c]);
          m_edge[c] = longint'(rs[c]);
        end
        if (!cnt_lock) e_valid = 1'b0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", nm, k_edge, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input logic [63:0] act, input longint lo, input longint hi);
    n_cmp++;
    if ($isunknown(act) || longint'(act) < lo || longint'(act) > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("d32.high[%0d]", c), 64'(hc32[c*32 +: 32]), e_high[0][c]);
      chk($sformatf("d8.high[%0d]", c),  64'(hc8[c*8 +: 8]),    e_high[1][c]);
`ifdef MEASURE_DUTY_EDGE_CNT_EN
      chk($sformatf("d32.edge[%0d]", c), 64'(ec32[c*32 +: 32]), e_edge[0][c]);
      chk($sformatf("d8.edge[%0d]", c),  64'(ec8[c*8 +: 8]),    e_edge[1][c]);
`endif
    end
    chk("d32.total", 64'(tc32), e_total[0]);
    chk("d8.total",  64'(tc8),  e_total[1]);
    chk("d32.ovf",   64'(ov32), 64'(e_ovf[0]));
    chk("d8.ovf",    64'(ov8),  64'(e_ovf[1]));
    chk("d32.valid", 64'(v32),  64'(e_valid));
    chk("d8.valid",  64'(v8),   64'(e_valid));
    chk("d32.dropped", 64'(dr32), 64'(e_dropped));
    chk("d8.dropped",  64'(dr8),  64'(e_dropped));
  endtask

  task automatic tick();
    @(posedge clk);
    sig_hist[k_edge] = sig_in;
    model_step(k_edge);
    k_edge++;
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    int        len;
    int        gap;
    logic      lock;
    logic [3:0] sig;
    longint    exp_total;
    longint    exp_total8;
    longint    exp_high1;
    logic      exp_valid;
    logic      exp_dropped;
  } win_t;

  win_t tbl [5];

  initial begin
    int ph;
    rst_n = 1'b0; gate = 1'b0; cnt_lock = 1'b0; sig_in = '0;
    @(negedge clk);
    ticks(2);
    rst_n = 1'b1;
    tick();
    chk("reset.total", 64'(tc32), 64'd0);
    chk("reset.valid", 64'(v32), 64'd0);

    // Constant-signal windows with hand-computed results.
    tbl[0] = '{len: 5,   gap: 4, lock: 1'b0, sig: 4'b0010, exp_total: 5,   exp_total8: 5,   exp_high1: 5,   exp_valid: 1'b1, exp_dropped: 1'b0};
    tbl[1] = '{len: 1,   gap: 4, lock: 1'b0, sig: 4'b1111, exp_total: 1,   exp_total8: 1,   exp_high1: 1,   exp_valid: 1'b1, exp_dropped: 1'b0};
    tbl[2] = '{len: 20,  gap: 4, lock: 1'b1, sig: 4'b0010, exp_total: 1,   exp_total8: 1,   exp_high1: 1,   exp_valid: 1'b1, exp_dropped: 1'b1};
    tbl[3] = '{len: 7,   gap: 4, lock: 1'b0, sig: 4'b0000, exp_total: 7,   exp_total8: 7,   exp_high1: 0,   exp_valid: 1'b1, exp_dropped: 1'b0};
    tbl[4] = '{len: 260, gap: 4, lock: 1'b0, sig: 4'b0010, exp_total: 260, exp_total8: 255, exp_high1: 260, exp_valid: 1'b1, exp_dropped: 1'b0};
    for (int t = 0; t < 5; t++) begin
      sig_in = tbl[t].sig; cnt_lock = tbl[t].lock; gate = 1'b0;
      ticks(tbl[t].gap);
      gate = 1'b1; ticks(tbl[t].len);
      gate = 1'b0; ticks(2);
      chk($sformatf("tbl%0d.total", t),  64'(tc32), tbl[t].exp_total);
      chk($sformatf("tbl%0d.total8", t), 64'(tc8),  tbl[t].exp_total8);
      chk($sformatf("tbl%0d.high1", t),  64'(hc32[32 +: 32]), tbl[t].exp_high1);
      chk($sformatf("tbl%0d.valid", t),  64'(v32),  64'(tbl[t].exp_valid));
      chk($sformatf("tbl%0d.dropped", t), 64'(dr32), 64'(tbl[t].exp_dropped));
      cnt_lock = 1'b0;
    end

    // 1000-cycle window: ch0 50% / ch1 high / ch2 low / ch3 30%, period 10.
    ph = 0;
    gate = 1'b0;
    for (int i = 0; i < 1010; i++) begin
      sig_in = {(ph % 10) < 3, 1'b0, 1'b1, (ph % 10) < 5};
      gate = (i >= 10);
      tick(); ph++;
    end
    sig_in = {(ph % 10) < 3, 1'b0, 1'b1, (ph % 10) < 5};
    gate = 1'b0; tick();
    chk("duty.valid_at_fall", 64'(v32), 64'd0);
    tick();
    chk("duty.valid_after", 64'(v32), 64'd1);
    chk("duty.total", 64'(tc32), 64'd1000);
    chk_rng("duty.high0", 64'(hc32[0 +: 32]), 499, 501);
    chk("duty.high1", 64'(hc32[32 +: 32]), 64'd1000);
    chk("duty.high2", 64'(hc32[64 +: 32]), 64'd0);
    chk_rng("duty.high3", 64'(hc32[96 +: 32]), 299, 301);
`ifdef MEASURE_DUTY_EDGE_CNT_EN
    chk_rng("duty.edge0", 64'(ec32[0 +: 32]), 99, 101);
`endif

    // Saturation on the 8-bit instance.
    sig_in = 4'b0010; ticks(4);
    gate = 1'b1; ticks(300);
    gate = 1'b0; ticks(2);
    chk("sat.total8", 64'(tc8), 64'd255);
    chk("sat.high1_8", 64'(hc8[8 +: 8]), 64'd255);
    chk("sat.ovf8", 64'(ov8), 64'b10010);
    chk("sat.ovf32", 64'(ov32), 64'd0);

    // Lock: 50-cycle latched window, then a 100-cycle window under lock, then release.
    gate = 1'b1; ticks(50);
    gate = 1'b0; ticks(3);
    cnt_lock = 1'b1;
    gate = 1'b1; ticks(100);
    gate = 1'b0; ticks(3);
    chk("lock.total_held", 64'(tc32), 64'd50);
    chk("lock.dropped", 64'(dr32), 64'd1);
    chk("lock.valid", 64'(v32), 64'd1);
    cnt_lock = 1'b0;
    gate = 1'b1; ticks(20);
    gate = 1'b0; ticks(2);
    chk("unlock.total", 64'(tc32), 64'd20);
    chk("unlock.dropped", 64'(dr32), 64'd0);

    // Reset in the middle of a window.
    gate = 1'b1; ticks(39);
    rst_n = 1'b0; tick();
    chk("midrst.total", 64'(tc32), 64'd0);
    chk("midrst.high1", 64'(hc32[32 +: 32]), 64'd0);
    rst_n = 1'b1; gate = 1'b0; ticks(5);
    chk("midrst.valid", 64'(v32), 64'd0);
    gate = 1'b1; ticks(10);
    gate = 1'b0; ticks(2);
    chk("postrst.total", 64'(tc32), 64'd10);

    // Back-to-back windows separated by one low gate cycle.
    sig_in = 4'b0010; ticks(3);
    gate = 1'b1; ticks(30);
    gate = 1'b0; tick();
    gate = 1'b1; tick();
    chk("b2b.first_total", 64'(tc32), 64'd30);
    chk("b2b.first_high1", 64'(hc32[32 +: 32]), 64'd30);
    ticks(39);
    gate = 1'b0; ticks(2);
    chk("b2b.second_total", 64'(tc32), 64'd40);
    chk("b2b.second_high1", 64'(hc32[32 +: 32]), 64'd40);

    // Randomised windows, lock and occasional resets, checked every cycle by the model.
    for (int w = 0; w < 25; w++) begin
      int len, gap;
      len = $urandom_range(1, 300);
      gap = $urandom_range(1, 5);
      for (int i = 0; i < gap + len; i++) begin
        sig_in   = NC'($urandom);
        cnt_lock = ($urandom_range(0, 3) == 0);
        rst_n    = ($urandom_range(0, 299) != 0);
        gate     = (i >= gap);
        tick();
      end
      rst_n = 1'b1;
    end
    gate = 1'b0; cnt_lock = 1'b0; ticks(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
